ctrl_seq: RTL

- Control sequencer for the 9-bit datapath. It sits directly upstream of the 10-input bus multiplexer and generates that mux's 4-bit select.
- It also drives the register-file load enables, the A and G register loads, and the ALU add/sub control.
- It fetches one 9-bit instruction (IIIXXXYYY) from din, then steps a T0..T3 state machine until done.

---
 rtl/ctrl_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ctrl_seq.sv
// Control sequencer: fetches a 9-bit IIIXXXYYY instruction from din and steps T0..T3 to drive the bus mux select, register loads and ALU op.
// Latency: mv/mvi/NOP (and mvnz) finish 2 cycles after run is sampled, add/sub finish 4 cycles after; outputs are combinational from state/IR.
// Backpressure: none; run is only honoured in T0 and is ignored (not queued) while an instruction is in flight.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   run, din        start request and instruction/immediate word
//   g_zero          G register is zero (only consulted when CTRL_MVNZ_EN is defined)
//   ctrlVar         bus mux select: 0-7 = R0-R7, SEL_DIN = din, SEL_G = G, SEL_NONE = idle
//   r_in            one-hot register-file load enables R0..R7
//   a_in, g_in      A / G register loads
//   addsub          ALU op (0 add, 1 sub)
//   ir_in           IR capture strobe
//   done            last cycle of an instruction
//
// Build option: define CTRL_MVNZ_EN to decode opcode 100 as mvnz Rx,Ry; otherwise it is a NOP.
module ctrl_seq #(
    parameter logic [3:0] SEL_DIN  = 4'd8,
    parameter logic [3:0] SEL_G    = 4'd9,
    parameter logic [3:0] SEL_NONE = 4'd15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [8:0] din,
    input  logic       g_zero,
    output logic [3:0] ctrlVar,
    output logic [7:0] r_in,
    output logic       a_in,
    output logic       g_in,
    output logic       addsub,
    output logic       ir_in,
    output logic       done
);

    localparam logic [1:0] T0 = 2'd0;
    localparam logic [1:0] T1 = 2'd1;
    localparam logic [1:0] T2 = 2'd2;
    localparam logic [1:0] T3 = 2'd3;

    localparam logic [2:0] OP_MV   = 3'b000;
    localparam logic [2:0] OP_MVI  = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_MVNZ = 3'b100;

    logic [1:0] state_q, state_d;
    logic [8:0] ir_q, ir_d;

    logic [2:0] op_iii;
    logic [2:0] reg_x;
    logic [2:0] reg_y;
    logic [7:0] x_hot;

    assign op_iii = ir_q[8:6];
    assign reg_x  = ir_q[5:3];
    assign reg_y  = ir_q[2:0];
    // Single shifted bit guarantees r_in is one-hot or zero by construction.
    assign x_hot  = 8'b0000_0001 << reg_x;

`ifndef CTRL_MVNZ_EN
    // g_zero has no consumer when mvnz is not built in.
    logic unused_g_zero;
    assign unused_g_zero = g_zero;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= T0;
            ir_q    <= 9'd0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        ctrlVar = SEL_NONE;
        r_in    = 8'd0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        addsub  = 1'b0;
        ir_in   = 1'b0;
        done    = 1'b0;

        case (state_q)
            T0: begin
                // Gated with rst so the strobe reads idle while reset is held.
                ir_in = run & ~rst;
                if (run) begin
                    ir_d    = din;
                    state_d = T1;
                end
            end
            T1: begin
                case (op_iii)
                    OP_MV: begin
                        ctrlVar = {1'b0, reg_y};
                        r_in    = x_hot;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        ctrlVar = SEL_DIN;
                        r_in    = x_hot;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrlVar = {1'b0, reg_x};
                        a_in    = 1'b1;
                        state_d = T2;
                    end
`ifdef CTRL_MVNZ_EN
                    OP_MVNZ: begin
                        ctrlVar = {1'b0, reg_y};
                        r_in    = g_zero ? 8'd0 : x_hot;
                        done    = 1'b1;
                        state_d = T0;
                    end
`endif
                    default: begin
                        // Unused opcodes retire as a one-cycle NOP.
                        done    = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                ctrlVar = {1'b0, reg_y};
                g_in    = 1'b1;
                addsub  = op_iii[0];
                state_d = T3;
            end
            T3: begin
                ctrlVar = SEL_G;
                r_in    = x_hot;
                done    = 1'b1;
                state_d = T0;
            end
            default: begin
                state_d = T0;
            end
        endcase
    end

endmodule
